// File: rtl/vga_fb_arbiter.sv
// Arbitrates a single-port framebuffer RAM between VGA scan-out (fixed read slot every 4th pixel)
// and a pixel writer / whole-buffer clear engine sharing the remaining cycles.
module vga_fb_arbiter #(
  parameter int COLOR_W = 4,
  parameter int ADDR_W  = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         sx,
  input  logic [9:0]         sy,
  input  logic               de,
  input  logic               hsync,
  input  logic               vsync,
  output logic               de_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic [COLOR_W-1:0] pix_color,
  input  logic               wr_req,
  input  logic [7:0]         wr_x,
  input  logic [6:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               clr_start,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] FB_WIDTH = ADDR_W'(160);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(19199);

  logic [0:0]         state_reg, state_next;
  logic [ADDR_W-1:0]  clr_cnt_reg, clr_cnt_next;
  logic [COLOR_W-1:0] clr_color_reg, clr_color_next;
  logic [COLOR_W-1:0] cur_reg;
  logic               slot_q_reg;

  logic [9:0]        ny;
  logic              slot_line, slot_wrap, slot, free_cycle;
  logic [7:0]        rd_fx, rd_fy;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              wr_in_range, wr_go, clr_go;

  // Display fetch runs two pixels ahead of its block; the slot at sx==798 primes column 0 of the next line.
  always_comb begin
    ny         = (sy == 10'd524) ? 10'd0 : sy + 10'd1;
    slot_line  = (sx[1:0] == 2'd2) && (sx < 10'd638);
    slot_wrap  = (sx == 10'd798) && (ny < 10'd480);
    slot       = slot_line | slot_wrap;
    free_cycle = ~slot;
    rd_fx      = slot_line ? 8'((sx + 10'd2) >> 2) : 8'd0;
    rd_fy      = slot_line ? sy[9:2] : ny[9:2];
    rd_addr    = ADDR_W'(rd_fy) * FB_WIDTH + ADDR_W'(rd_fx);
    wr_addr    = ADDR_W'(wr_y) * FB_WIDTH + ADDR_W'(wr_x);
  end

  always_comb begin
    wr_in_range = (wr_x < 8'd160) && (wr_y < 7'd120);
    wr_ready    = free_cycle && (state_reg == ST_IDLE);
    wr_go       = wr_req && wr_ready && wr_in_range;
    clr_go      = free_cycle && (state_reg == ST_CLEAR);
    clr_busy    = (state_reg == ST_CLEAR);
  end

  always_comb begin
    mem_addr  = rd_addr;
    mem_we    = 1'b0;
    mem_wdata = wr_data;
    if (clr_go) begin
      mem_addr  = clr_cnt_reg;
      mem_we    = 1'b1;
      mem_wdata = clr_color_reg;
    end else if (wr_go) begin
      mem_addr  = wr_addr;
      mem_we    = 1'b1;
      mem_wdata = wr_data;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_cnt_next   = clr_cnt_reg;
    clr_color_next = clr_color_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr_start) begin
          state_next     = ST_CLEAR;
          clr_cnt_next   = '0;
          clr_color_next = clr_color;
        end
      end
      default: begin
        // Only free cycles advance the fill, so display slots are never taken.
        if (free_cycle) begin
          clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
          if (clr_cnt_reg == CLR_LAST) begin
            state_next = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      clr_cnt_reg   <= '0;
      clr_color_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clr_cnt_reg   <= clr_cnt_next;
      clr_color_reg <= clr_color_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q_reg <= 1'b0;
      cur_reg    <= '0;
      pix_color  <= '0;
      de_o       <= 1'b0;
      hsync_o    <= 1'b1;
      vsync_o    <= 1'b1;
    end else begin
      slot_q_reg <= slot;
      if (slot_q_reg) begin
        cur_reg <= mem_rdata;
      end
      pix_color <= de ? cur_reg : '0;
      de_o      <= de;
      hsync_o   <= hsync;
      vsync_o   <= vsync;
    end
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares one single-port synchronous video RAM between VGA scan-out and a pixel-write requester. The framebuffer holds 160x120 pixels; each one covers a 4x4 block of the 640x480 screen. The block sits between the 800x525 timing generator (sx, sy, de, hsync, vsync) and the VGA output pins. It reserves a fixed read slot for the display every fourth pixel and gives all other cycles to the writer or to a built-in clear engine.

## Interface
- COLOR_W, 4, bits per framebuffer pixel
- ADDR_W, 15, RAM address width (19200 words used)
- clk  input  1  pixel clock
- reset_n  input  1  asynchronous, active-low reset
- sx  input  10  horizontal position, 0..799
- sy  input  10  vertical position, 0..524
- de, hsync, vsync  input  1 each  timing-generator outputs
- de_o, hsync_o, vsync_o  output  1 each  inputs delayed by one cycle
- pix_color  output  COLOR_W  colour for the pixel shown by de_o; 0 when de_o=0
- wr_req  input  1  write request
- wr_x  input  8  framebuffer column
- wr_y  input  7  framebuffer row
- wr_data  input  COLOR_W  write colour
- wr_ready  output  1  write accepted this cycle when wr_req & wr_ready
- clr_start  input  1  one-cycle pulse; start a fill of the whole framebuffer
- clr_color  input  COLOR_W  fill colour, sampled on clr_start
- clr_busy  output  1  clear in progress
- mem_addr  output  ADDR_W  RAM address
- mem_we  output  1  RAM write enable
- mem_wdata  output  COLOR_W  RAM write data
- mem_rdata  input  COLOR_W  RAM read data, valid the cycle after the read address

## Operation
- Address map: addr = fy*160 + fx.
- **Display slot**
  - A display slot occurs when sx[1:0]==2 and either condition holds:
    - sx<638: read fx=(sx+2)>>2, fy=sy>>2.
    - sx==798 and the next line ny is <480: read fx=0, fy=ny>>2. Here ny=(sy==524)?0:sy+1.
  - In a display slot, mem_addr carries the read address, mem_we=0 and wr_ready=0.
  - All other cycles are free.
- **Capture**
  - On the edge that ends the cycle after a display slot, register cur <= mem_rdata.
  - This cycle has sx[1:0]==3 or sx==799.
- **Output register**
  - Each edge: pix_color <= de ? cur : 0.
  - hsync_o, vsync_o and de_o take the input values on the same edge.
- **Writer**
  - wr_ready = free cycle & state==IDLE. It is combinational from sx, sy and state.
  - On an accepted write with wr_x<160 and wr_y<120: mem_we=1, mem_addr from wr_x/wr_y, mem_wdata=wr_data.
  - On an accepted write that is out of range: accepted (wr_ready=1) but mem_we=0 and the write is dropped.
- **Clear FSM, states IDLE and CLEAR**
  - IDLE -> CLEAR on clr_start. The edge latches clr_color and sets the clear counter to 0.
  - In CLEAR, every free cycle writes addr=counter with the latched colour, then increments the counter.
  - After the write to 19199: CLEAR -> IDLE.
  - clr_start while in CLEAR is ignored.
  - clr_busy = (state==CLEAR).
- When there is no access, mem_we=0 and mem_addr holds any value.

## Timing
- Reset (async assert, synchronous use after release):
  - pix_color=0, cur=0, de_o=0, hsync_o=1, vsync_o=1.
  - State IDLE, clr_busy=0, counter=0.
- mem_* outputs are combinational; RAM read latency is 1 cycle.
- Screen pixel latency from sx/sy/de to pix_color/de_o: 1 cycle. sync and de stay aligned.
- cur always holds column sx>>2 during the active cycle for sx. No pixel tearing is allowed within a 4-pixel block.
- Same-cycle clr_start and wr_req in IDLE: the write is served if the cycle is free, and CLEAR starts on the next cycle.
- Clear length: exactly 19200 writes, each address once, spread across free cycles only. Display slots are never stolen.
- Reset asserted mid-clear: immediate return to IDLE and clr_busy=0. The partial fill remains and the clear does not resume.
- Input combinations outside 0..799 / 0..524 are undefined.

## Test plan
- **Reset:** hold reset_n=0 with random inputs -> pix_color=0, hsync_o=vsync_o=1, de_o=0, clr_busy=0. Release and mem traffic starts on the next slot.
- **Scan-out:** preload RAM model with mem[a]=a[3:0] and run one frame.
  - pix_color is mem[0] for sx=0..3, sy=0.
  - pix_color is mem[1] for sx=4..7.
  - pix_color is mem[160] for sy=4, sx=0.
  - pix_color is mem[19199] for sx=639, sy=479.
  - pix_color is 0 in blanking.
  - Each of these is one cycle after the matching sx.
- **Slot conflict:** hold wr_req with x=5, y=3, data=0x7 from sx=2.
  - At sx=2: wr_ready=0 and a read at addr 1.
  - At sx=3: accepted, mem_we=1, addr 485, wdata=0x7.
- **Out-of-range write:** wr_x=160, wr_y=0 in blanking -> wr_ready=1, mem_we=0.
- **Clear:** clr_start with clr_color=0xA.
  - clr_busy rises on the next cycle and wr_ready=0 throughout.
  - The scoreboard sees every address 0..19199 written once with 0xA, and display reads stay on schedule.
  - A second clr_start mid-clear has no effect.
  - After the clear, the next frame shows 0xA everywhere active.
- **Reset mid-clear:** assert reset_n=0 after 1000 clear writes -> clr_busy=0 at once. No further clear writes follow, and addresses >=1000 keep their old data.
